mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit for the MIPS subset core: a Moore/Mealy FSM that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It handshakes with a shared instruction/data memory and emits per-cycle datapath controls. It replaces the single-cycle combinational decoder, keeps that decoder's ALUOp encoding, and adds sequencing, memory wait states, illegal-instruction trapping and optional performance counters.

## Interface
- ALUOP_W, 3: ALUOp output width, minimum 3; codes are zero-extended when wider.
- CNT_W, 32: width of the performance counters. Only used with MC_CTRL_PERF_EN.
- clk  in  1  single clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- opcode  in  6  IR[31:26]. Valid from the DECODE cycle onward.
- funct  in  6  IR[5:0]. Valid from the DECODE cycle onward.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request. Held until mem_ready.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- IRWrite, PCWrite  out  1 each  IR load and PC+4 load.
- ALUOp  out  ALUOP_W  ALU operation code.
- ALUSrc, RegDst, RegWrite, MemtoReg, MemRead, MemWrite, Branch, Jump  out  1 each  same meaning as on the single-cycle decoder.
- illegal  out  1  sticky trap flag.
- cycle_cnt, instr_cnt  out  CNT_W each  present only with MC_CTRL_PERF_EN.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH
  - Outputs: mem_req=1, MemRead=1, IorD=0.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle (Mealy), and next state is DECODE.
  - Otherwise the state holds.
- DECODE
  - Latches opcode and funct into an internal class register. EXEC, MEM and WB decode only from this latched value.
  - Unknown opcode, or unknown funct with opcode 0, goes to TRAP.
- ALUOp codes
  - 000 logic
  - 001 compare (beq, bne)
  - 010 add (add, addi, lw, sw)
  - 011 sub
  - 100 sll, sllv
  - 101 srl, srlv
  - 110 sra, srav
  - 111 slt, sltu, slti, sltiu
  - andi, ori, xori and lui use 000.
- Paths by instruction class:
  - R-type ALU: EXEC (ALUOp) → WB (RegDst=1, RegWrite=1) → FETCH.
  - I-type ALU: EXEC (ALUSrc=1, ALUOp) → WB (ALUSrc=1, RegWrite=1) → FETCH.
  - lw: EXEC (ALUSrc=1, ALUOp=010) → MEM (mem_req, MemRead, IorD=1) → WB (MemtoReg=1, RegWrite=1) → FETCH.
  - sw: EXEC → MEM (mem_req, MemWrite, IorD=1) → FETCH.
  - beq/bne: EXEC (ALUOp=001, Branch=1) → FETCH.
  - j/jr: EXEC (Jump=1) → FETCH.
  - jal: EXEC (Jump=1) → WB (RegWrite=1) → FETCH.
- MEM holds while mem_ready=0. MemRead or MemWrite stays asserted for the whole wait.
- TRAP
  - illegal=1; all other outputs are 0.
  - Exited only by reset.
- All controls not listed for a state are 0.

## Timing
- While rst=1, every output is 0, including counters and illegal. This is forced asynchronously, not waiting for a clock edge.
- After rst deasserts, the first state is FETCH.
- Minimum latency with mem_ready tied to 1:
  - 3 cycles: branch, jump.
  - 4 cycles: R-type, I-type, jal, sw.
  - 5 cycles: lw.
- Each mem_ready=0 cycle in FETCH or MEM adds one cycle.
- mem_ready outside FETCH and MEM is ignored.
- mem_req never drops before the mem_ready cycle.
- Reset asserted mid-access (any state) aborts at once. No partial write-enable remains high.
- opcode/funct changes after DECODE have no effect.

## Configuration
- MC_CTRL_PERF_EN defined:
  - cycle_cnt increments every cycle while out of reset and not in TRAP.
  - instr_cnt increments on each transition into FETCH from EXEC, MEM or WB.
  - Both wrap modulo 2^CNT_W.
- MC_CTRL_PERF_EN undefined: the counters, their logic and their ports are absent.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum;
  - instruction-class enum;
  - ALUOp code constants;
  - opcode and funct constants.
- Sub-module mc_ctrl_decode: purely combinational, maps (opcode, funct) to (class, ALUOp, illegal). Instantiated once.
- The FSM, the latched class register and the output logic live in mc_ctrl.

## Test plan
- add (opcode 0, funct 100000), mem_ready=1 → states FETCH, DECODE, EXEC, WB.
  - EXEC: ALUOp=010.
  - WB: RegDst=1, RegWrite=1.
  - Back in FETCH on cycle 5.
- lw (100011), mem_ready low for 3 MEM cycles → MEM lasts 4 cycles with MemRead=1, IorD=1 throughout; WB has MemtoReg=1, RegWrite=1; total 8 cycles.
- beq (000100) → EXEC has Branch=1, ALUOp=001; no RegWrite at any point; back in FETCH after 3 cycles.
- opcode 111111 → TRAP after DECODE; illegal=1 and all write enables 0 for 10+ cycles; rst clears illegal.
- rst pulsed mid-MEM of sw → MemWrite drops within the same cycle; FETCH follows rst release.
- MC_CTRL_PERF_EN with 3 back-to-back adds → instr_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl shared types: FSM states, instruction classes,
// ALUOp codes and MIPS opcode/funct constants.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_RALU,
    C_IALU,
    C_LW,
    C_SW,
    C_BR,
    C_JMP,
    C_JAL,
    C_ILL
  } cls_t;

  localparam logic [2:0] ALU_LOGIC = 3'b000;
  localparam logic [2:0] ALU_CMP   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_SLL   = 3'b100;
  localparam logic [2:0] ALU_SRL   = 3'b101;
  localparam logic [2:0] ALU_SRA   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl instruction decoder: (opcode, funct) to
// instruction class, 3-bit ALUOp and illegal flag.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [2:0] aluop,
  output logic       illegal
);

  always_comb begin
    cls   = C_ILL;
    aluop = ALU_LOGIC;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        cls = C_RALU;
        unique case (1'b1)
          (funct == F_ADD),
          (funct == F_ADDU): aluop = ALU_ADD;
          (funct == F_SUB),
          (funct == F_SUBU): aluop = ALU_SUB;
          (funct == F_AND),
          (funct == F_OR),
          (funct == F_XOR),
          (funct == F_NOR):  aluop = ALU_LOGIC;
          (funct == F_SLL),
          (funct == F_SLLV): aluop = ALU_SLL;
          (funct == F_SRL),
          (funct == F_SRLV): aluop = ALU_SRL;
          (funct == F_SRA),
          (funct == F_SRAV): aluop = ALU_SRA;
          (funct == F_SLT),
          (funct == F_SLTU): aluop = ALU_SLT;
          (funct == F_JR):   cls = C_JMP;
          default:           cls = C_ILL;
        endcase
      end
      (opcode == OP_J):   cls = C_JMP;
      (opcode == OP_JAL): cls = C_JAL;
      (opcode == OP_BEQ),
      (opcode == OP_BNE): begin
        cls   = C_BR;
        aluop = ALU_CMP;
      end
      (opcode == OP_ADDI): begin
        cls   = C_IALU;
        aluop = ALU_ADD;
      end
      (opcode == OP_SLTI),
      (opcode == OP_SLTIU): begin
        cls   = C_IALU;
        aluop = ALU_SLT;
      end
      (opcode == OP_ANDI),
      (opcode == OP_ORI),
      (opcode == OP_XORI),
      (opcode == OP_LUI): cls = C_IALU;
      (opcode == OP_LW): begin
        cls   = C_LW;
        aluop = ALU_ADD;
      end
      (opcode == OP_SW): begin
        cls   = C_SW;
        aluop = ALU_ADD;
      end
      default: cls = C_ILL;
    endcase
    illegal = (cls == C_ILL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with memory waits and trap.
// Define MC_CTRL_PERF_EN to add cycle_cnt/instr_cnt counters.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrc,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic               Jump,
  output logic               illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  state_t     state;
  cls_t       cls_q;
  logic [2:0] alu_q;

  cls_t       dec_cls;
  logic [2:0] dec_alu;
  logic       dec_ill;

  mc_ctrl_decode u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .aluop   (dec_alu),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      cls_q <= C_ILL;
      alu_q <= ALU_LOGIC;
    end else begin
      unique case (state)
        S_FETCH:
          if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          cls_q <= dec_cls;
          alu_q <= dec_alu;
          state <= dec_ill ? S_TRAP : S_EXEC;
        end
        S_EXEC:
          unique case (cls_q)
            C_RALU, C_IALU, C_JAL: state <= S_WB;
            C_LW, C_SW:            state <= S_MEM;
            default:               state <= S_FETCH;
          endcase
        S_MEM:
          if (mem_ready)
            state <= (cls_q == C_LW) ? S_WB : S_FETCH;
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // rst gates everything so FETCH's request drops without a clock
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUOp    = '0;
    ALUSrc   = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    illegal  = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ;
        S_EXEC: begin
          ALUOp = ALUOP_W'(alu_q);
          unique case (cls_q)
            C_IALU, C_LW, C_SW: ALUSrc = 1'b1;
            C_BR:               Branch = 1'b1;
            C_JMP, C_JAL:       Jump   = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemRead  = (cls_q == C_LW);
          MemWrite = (cls_q == C_SW);
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = (cls_q == C_RALU);
          ALUSrc   = (cls_q == C_IALU);
          MemtoReg = (cls_q == C_LW);
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    unique case (state)
      S_EXEC:
        retire = (cls_q == C_BR) ||
                 (cls_q == C_JMP);
      S_MEM:
        retire = mem_ready &&
                 (cls_q == C_SW);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_TRAP)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)
        instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule
